serial_subtractor: RTL and testbench

//  Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_if.sv | 30 +++
 rtl/serial_subtractor_full_adder_cell.sv | 15 +
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// State encoding and the majority helper used by the full-adder cell.
package serial_subtractor_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic majority3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The master drives operands and accepts results; the slave is the subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf, zero
  );

endinterface

// File: rtl/serial_subtractor_full_adder_cell.sv
// Single-bit combinational full adder; the only arithmetic element of the subtractor.
module serial_subtractor_full_adder_cell
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = majority3(a, b, cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit per clock.
// Computes a + ~b + 1 with one full-adder cell; carry flop starts at 1.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MsbCnt  = CNT_W'(WIDTH - 2);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] diff_sh_q;
  logic             c_q;
  logic             c_msb_in_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] diff_next;

  serial_subtractor_full_adder_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Value of the diff shift register after the current bit lands in its MSB.
  assign diff_next = {fa_s, diff_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      diff_sh_q   <= '0;
      c_q         <= 1'b0;
      c_msb_in_q  <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            a_sh_q     <= bus.a;
            b_sh_q     <= ~bus.b;
            c_q        <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StBusy;
            in_ready_q <= 1'b0;
          end
        end
        StBusy: begin
          a_sh_q    <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q    <= {1'b0, b_sh_q[WIDTH-1:1]};
          diff_sh_q <= diff_next;
          c_q       <= fa_cout;
          if (cnt_q == MsbCnt) begin
            c_msb_in_q <= fa_cout;
          end
          if (cnt_q == LastCnt) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            diff_q      <= diff_next;
            borrow_q    <= ~fa_cout;
            ovf_q       <= c_msb_in_q ^ fa_cout;
            zero_q      <= (diff_next == '0);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_valid_q && bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=8, plus exhaustive WIDTH=4.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  int checks;
  int passed;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_ready8();
    int n;
    n = 0;
    while (bus8.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready8", 32'(bus8.in_ready), 32'd1);
  endtask

  // One full transaction; hold = backpressure cycles, poke = inject operands during BUSY.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] e_diff, input logic e_borrow, input logic e_ovf,
                      input logic e_zero, input int hold, input bit poke);
    int n;
    wait_ready8();
    bus8.a        = a;
    bus8.b        = b;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check({tag, ".busy_ready"}, 32'(bus8.in_ready), 32'd0);
    n = 0;
    while (bus8.out_valid !== 1'b1 && n < 40) begin
      if (poke && n == 1) begin
        bus8.a        = ~a;
        bus8.b        = a;
        bus8.in_valid = 1'b1;
      end
      @(negedge clk);
      bus8.in_valid = 1'b0;
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'd8);
    check({tag, ".diff"}, 32'(bus8.diff), 32'(e_diff));
    check({tag, ".borrow"}, 32'(bus8.borrow), 32'(e_borrow));
    check({tag, ".ovf"}, 32'(bus8.ovf), 32'(e_ovf));
    check({tag, ".zero"}, 32'(bus8.zero), 32'(e_zero));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(bus8.out_valid), 32'd1);
      check({tag, ".hold_diff"}, {bus8.zero, bus8.ovf, bus8.borrow, bus8.diff},
            {e_zero, e_ovf, e_borrow, e_diff});
      check({tag, ".hold_ready"}, 32'(bus8.in_ready), 32'd0);
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check({tag, ".post_ready"}, 32'(bus8.in_ready), 32'd1);
    check({tag, ".post_valid"}, 32'(bus8.out_valid), 32'd0);
    check({tag, ".post_diff"}, 32'(bus8.diff), 32'(e_diff));
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    int n;
    logic [3:0] e_diff;
    e_diff = a - b;
    n = 0;
    while (bus4.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus4.a        = a;
    bus4.b        = b;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    n = 0;
    while (bus4.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w4.latency", 32'(n), 32'd4);
    check("w4.result", {bus4.zero, bus4.ovf, bus4.borrow, bus4.diff},
          {e_diff == 4'd0, (a[3] != b[3]) && (e_diff[3] != a[3]), a < b, e_diff});
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rd;
    checks         = 0;
    passed         = 0;
    rst_n          = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst.out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst.results", {bus8.zero, bus8.ovf, bus8.borrow, bus8.diff}, 32'd0);
    check("rst4.handshake", {bus4.in_ready, bus4.out_valid}, 32'b10);
    rst_n = 1'b1;
    @(negedge clk);

    run8("t1", 8'd5, 8'd3, 8'h02, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run8("t2", 8'd3, 8'd5, 8'hFE, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run8("t3a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run8("t3b", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    run8("t4", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 10, 1'b0);
    // Operands poked mid-BUSY are ~8'h64 and 8'h64; result must still be 8'h64 - 8'h21.
    run8("t5", 8'h64, 8'h21, 8'h43, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Reset when cnt==3: in_ready/out_valid must react without a clock edge.
    wait_ready8();
    bus8.a        = 8'h3C;
    bus8.b        = 8'h11;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6.rst_ready", 32'(bus8.in_ready), 32'd1);
    check("t6.rst_valid", 32'(bus8.out_valid), 32'd0);
    check("t6.rst_diff", 32'(bus8.diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run8("t6", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = (i % 50 == 0) ? ra : ((i % 50 == 1) ? 8'h00 : 8'($urandom));
      rd = ra - rb;
      run8("rnd", ra, rb, rd, ra < rb, (ra[7] != rb[7]) && (rd[7] != ra[7]), rd == 8'h00,
           0, 1'b0);
    end

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run4(4'(x), 4'(y));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
